i2s_receiver: RTL
=================

Name: i2s_receiver

Overview:
- Receive side of the team's I2S link: samples externally driven sck/ws/sd and deserializes MSB-first words of BITS bits.
- Presents each word with its channel tag on a single-entry ready/valid output register.
- Pairs with the I2S controller (transmitter) on the same board or loopback bench.
- sck/ws/sd are asynchronous to clk: synchronized internally, sck edges detected in the clk domain.

Parameters:
- BITS, 8, data word width in bits (2..16)
- SYNC_STAGES, 2, synchronizer flops on sck/ws/sd (>=2)

Ports:
- clk  input  1  system clock (12 MHz nominal)
- rst  input  1  synchronous reset, active-high
- sck  input  1  I2S serial clock from external controller, async
- ws  input  1  I2S word select (0=left, 1=right), async
- sd  input  1  I2S serial data, async
- o_data  output  BITS  received word, MSB first on the wire
- o_ws  output  1  channel tag: ws value at the word's boundary edge
- o_valid  output  1  o_data/o_ws valid
- o_ready  input  1  downstream accepts when o_valid & o_ready
- o_overflow  output  1  sticky: completed word dropped because output full
- o_short_err  output  1  one-cycle pulse: word truncated by early ws change

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0; shift register and bit counter 0; synchronizer and edge-history flops 0; state S_SYNC.
- Synchronization: sck, ws and sd each pass through SYNC_STAGES flops plus one history flop on sck.
- Rising-edge event (rise): synced sck=1 and history=0; lasts exactly one clk cycle.
- Falling sck edges are ignored.
- Timing requirement: sck high and low time each >=3 clk cycles; the bench must honour this.
- On each rise: sample synced sd and synced ws together. ws_prev holds ws from the previous rise (0 after reset).
- Boundary edge: a rise where ws != ws_prev.
- FSM:
  - S_SYNC: ignore all bits until the first boundary edge, then latch tag=ws, clear bit counter, go to S_DELAY. Words are never emitted before the first boundary.
  - S_DELAY (I2S one-bit delay): the sd sampled on the boundary edge itself is discarded. The next rise goes to S_SHIFT and that rise's sd is the MSB: shift in, count=1.
  - S_SHIFT: each rise shifts sd in at the LSB, shifting left, count+1. When count reaches BITS, the word completes and the state goes to S_WAIT.
  - S_WAIT: extra bits in the slot are ignored. A boundary edge latches the new tag, clears the count and goes to S_DELAY.
  - Boundary edge in S_SHIFT with count<BITS: partial word discarded, o_short_err=1 for one cycle, new tag latched, go to S_DELAY.
  - Boundary edge in S_DELAY (count 0): same as the S_SHIFT truncation case, including the o_short_err pulse.
- Word completion (count reaches BITS):
  - Completion is the cycle after the final rise. o_data, o_ws and o_valid=1 are registered in that same cycle, so latency is 1 clk from the final-bit rise.
  - If o_valid=1 and o_ready=0 at completion: the new word is dropped, the old word is held unchanged, and o_overflow is set. o_overflow clears only on rst.
  - If o_valid=1 and o_ready=1 in the completion cycle: the old word is consumed and the new word is loaded; o_valid stays 1 with no bubble and no overflow.
- Handshake:
  - o_valid stays high until o_valid & o_ready; it then drops the next cycle unless a word completes in that same cycle.
  - o_data and o_ws are stable while o_valid=1 and o_ready=0.
- Reset mid-word: rst wins over everything; the partial word is lost; the FSM returns to S_SYNC and waits for a fresh boundary.
- sck stopped: the FSM holds state indefinitely; there is no timeout.

Optional Feature:
- Macro: I2S_RX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. The boundary edge's sd is the MSB: shift it in, set count=1, and go directly to S_SHIFT. S_DELAY is unused. A boundary edge with count<BITS still raises o_short_err.
- Undefined: standard I2S one-bit-delay behaviour as above.

Test Plan:
- Reset then idle: rst 2 cycles, sck toggling with ws constant 0 and sd=1 -> o_valid stays 0, o_overflow=0, o_short_err never pulses (no boundary seen).
- Single word: BITS=8, ws 0->1, then delay slot, then 0xA5 MSB first, 1 spare bit, then ws->0; o_ready=1 -> one o_valid pulse with o_data=0xA5, o_ws=1, asserted 1 clk after the 8th data rise.
- Stereo stream, o_ready=1: alternating 9-sck slots left=0x3C, right=0xC3 for 4 frames -> 8 words in order, tags 0,1,0,1..., no overflow.
- Backpressure: o_ready=0 across two completed words (0x11 then 0x22) -> o_data holds 0x11, o_overflow=1 after the 2nd completion; raise o_ready -> 0x11 accepted, o_valid drops, o_overflow stays 1.
- Short word: ws toggles after only 5 data bits -> o_short_err pulses once, no o_valid; the following full slot of 0x7E is delivered correctly.
- Reset mid-word plus macro: rst asserted after 4 bits -> nothing emitted until the next boundary. With I2S_RX_LEFT_JUSTIFIED_EN, 0x81 sent with its MSB on the boundary edge -> o_data=0x81.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S receive deserializer: syncs sck/ws/sd, shifts MSB-first words, presents them on a ready/valid register.
// Latency 1 clk from final-bit rise; a full output register drops new words (sticky overflow). Macro: I2S_RX_LEFT_JUSTIFIED_EN.
module i2s_receiver #(
  parameter int BITS        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sck,
  input  logic            ws,
  input  logic            sd,
  output logic [BITS-1:0] o_data,
  output logic            o_ws,
  output logic            o_valid,
  input  logic            o_ready,
  output logic            o_overflow,
  output logic            o_short_err
);

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic                   sck_hist, ws_prev, tag;
  logic                   sck_s, ws_s, sd_s;
  logic                   rise, boundary, complete;
  logic [1:0]             state;
  logic [BITS-1:0]        shreg, next_word;
  logic [CW-1:0]          count;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ws_s      = ws_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign rise      = sck_s & ~sck_hist;
  assign boundary  = rise & (ws_s != ws_prev);
  assign next_word = {shreg[BITS-2:0], sd_s};
  // A boundary on the last bit still truncates: the word never completes.
  assign complete  = rise & ~boundary & (state == S_SHIFT) & (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync    <= '0;
      ws_sync     <= '0;
      sd_sync     <= '0;
      sck_hist    <= 1'b0;
      ws_prev     <= 1'b0;
      tag         <= 1'b0;
      state       <= S_SYNC;
      shreg       <= '0;
      count       <= '0;
      o_data      <= '0;
      o_ws        <= 1'b0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_short_err <= 1'b0;
    end else begin
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], sck};
      ws_sync     <= {ws_sync[SYNC_STAGES-2:0], ws};
      sd_sync     <= {sd_sync[SYNC_STAGES-2:0], sd};
      sck_hist    <= sck_s;
      o_short_err <= 1'b0;

      if (rise) begin
        ws_prev <= ws_s;
        if (boundary) begin
          tag <= ws_s;
          if (state == S_SHIFT || state == S_DELAY)
            o_short_err <= 1'b1;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
          shreg <= {{(BITS-1){1'b0}}, sd_s};
          count <= CW'(1);
          state <= S_SHIFT;
`else
          count <= '0;
          state <= S_DELAY;
`endif
        end else begin
          case (state)
            S_DELAY: begin
              shreg <= {{(BITS-1){1'b0}}, sd_s};
              count <= CW'(1);
              state <= S_SHIFT;
            end
            S_SHIFT: begin
              shreg <= next_word;
              count <= count + 1'b1;
              if (count == LAST)
                state <= S_WAIT;
            end
            default: ;
          endcase
        end
      end

      // Same-cycle consume and load keeps o_valid high with no bubble.
      if (complete) begin
        if (!o_valid || o_ready) begin
          o_data  <= next_word;
          o_ws    <= tag;
          o_valid <= 1'b1;
        end else begin
          o_overflow <= 1'b1;
        end
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
